// File: rtl/digit_scan_ctrl.sv
// Scan controller for a 4-to-16 digit-select decoder. Each digit slot starts with a blanking
// period and then shows the digit. Display data is double-buffered and swapped at frame wrap.
module digit_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  output logic [3:0]            sel,
  output logic                  dec_en,
  output logic [3:0]            nibble,
  output logic                  frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [3:0]    SEL_LAST = 4'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  localparam state_t SLOT_START = (BLANK > 0) ? S_BLANK : S_SHOW;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [3:0]          sel_n;
  logic                wrap;
  logic [4*DIGITS-1:0] active, active_n;
  logic [4*DIGITS-1:0] pending, pending_n;
  logic                pend_flag, pend_flag_n;

  function automatic logic [3:0] pick_nibble(input logic [4*DIGITS-1:0] d, input logic [3:0] s);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (s == 4'(i)) r = d[4*i +: 4];
    end
    return r;
  endfunction

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sel_n       = sel;
    wrap        = 1'b0;
    active_n    = active;
    pending_n   = pending;
    pend_flag_n = pend_flag;
    if (state == S_IDLE) begin
      cnt_n = '0;
      sel_n = 4'd0;
      if (load) active_n = digits_in;
      if (run) state_n = SLOT_START;
    end else if (!run) begin
      // Stopping abandons the slot but still applies any queued frame so it is not lost.
      state_n = S_IDLE;
      cnt_n   = '0;
      sel_n   = 4'd0;
      if (load) begin
        active_n    = digits_in;
        pend_flag_n = 1'b0;
      end else if (pend_flag) begin
        active_n    = pending;
        pend_flag_n = 1'b0;
      end
    end else begin
      if (cnt == CNT_LAST) begin
        cnt_n   = '0;
        state_n = SLOT_START;
        if (sel == SEL_LAST) begin
          sel_n = 4'd0;
          wrap  = 1'b1;
        end else begin
          sel_n = sel + 4'd1;
        end
      end else begin
        cnt_n   = cnt + CW'(1);
        state_n = (int'(cnt_n) >= BLANK) ? S_SHOW : S_BLANK;
      end
      // Buffer swap only at frame wrap so a frame never mixes old and new digits.
      if (wrap) begin
        if (load) begin
          active_n    = digits_in;
          pend_flag_n = 1'b0;
        end else if (pend_flag) begin
          active_n    = pending;
          pend_flag_n = 1'b0;
        end
      end else if (load) begin
        pending_n   = digits_in;
        pend_flag_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sel        <= 4'd0;
      dec_en     <= 1'b0;
      nibble     <= 4'd0;
      frame_done <= 1'b0;
      active     <= '0;
      pending    <= '0;
      pend_flag  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel        <= sel_n;
      dec_en     <= (state_n == S_SHOW);
      nibble     <= pick_nibble(active_n, sel_n);
      frame_done <= wrap;
      active     <= active_n;
      pending    <= pending_n;
      pend_flag  <= pend_flag_n;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: a slot-arithmetic reference model queues expected
// outputs per clock for two configurations (4/8/2 and 16/1/0); a monitor compares them.
module tb_digit_scan_ctrl;

  logic        clk;
  logic        reset, run, load;
  logic [15:0] din1;
  logic [63:0] din2;
  logic [3:0]  sel1, nib1, sel2, nib2;
  logic        en1, fd1, en2, fd2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          scan;
    int          t;
    logic [63:0] act;
    logic [63:0] pend;
    bit          pf;
  } mst_t;

  typedef struct packed {
    logic [3:0] sel;
    logic       en;
    logic [3:0] nib;
    logic       fd;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  mst_t m1, m2;

  digit_scan_ctrl #(.DIGITS(4), .PRESCALE(8), .BLANK(2)) dut1 (
    .clk(clk), .reset(reset), .run(run), .load(load), .digits_in(din1),
    .sel(sel1), .dec_en(en1), .nibble(nib1), .frame_done(fd1));

  digit_scan_ctrl #(.DIGITS(16), .PRESCALE(1), .BLANK(0)) dut2 (
    .clk(clk), .reset(reset), .run(run), .load(load), .digits_in(din2),
    .sel(sel2), .dec_en(en2), .nibble(nib2), .frame_done(fd2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // t = clocks since the scan started; slot, digit and blank phase follow by division.
  task automatic step(input mst_t mi, input int D, input int P, input int B,
                      input logic r, input logic rn, input logic ld, input logic [63:0] d,
                      output mst_t mo, output exp_t e);
    mst_t m;
    bit   wrap;
    bit   en;
    int   s;
    m = mi; wrap = 0; en = 0; s = 0;
    if (r) begin
      m.scan = 0; m.t = 0; m.act = '0; m.pend = '0; m.pf = 0;
    end else if (!m.scan) begin
      if (ld) m.act = d;
      if (rn) begin m.scan = 1; m.t = 0; end
    end else if (!rn) begin
      m.scan = 0;
      if (ld) begin m.act = d; m.pf = 0; end
      else if (m.pf) begin m.act = m.pend; m.pf = 0; end
    end else begin
      m.t++;
      wrap = (m.t % (D * P)) == 0;
      if (wrap) begin
        if (ld) begin m.act = d; m.pf = 0; end
        else if (m.pf) begin m.act = m.pend; m.pf = 0; end
      end else if (ld) begin
        m.pend = d; m.pf = 1;
      end
    end
    if (m.scan) begin
      s  = (m.t / P) % D;
      en = (m.t % P) >= B;
    end
    e.sel = 4'(s);
    e.en  = en;
    e.nib = m.act[s*4 +: 4];
    e.fd  = wrap;
    mo = m;
  endtask

  initial begin
    exp_t e;
    mst_t n;
    m1 = '{0, 0, '0, '0, 0};
    m2 = '{0, 0, '0, '0, 0};
    forever begin
      @(posedge clk);
      step(m1, 4, 8, 2, reset, run, load, {48'd0, din1}, n, e);
      m1 = n;
      q1.push_back(e);
      step(m2, 16, 1, 0, reset, run, load, din2, n, e);
      m2 = n;
      q2.push_back(e);
    end
  end

  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      a = {sel1, en1, nib1, fd1};
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL dut1 no expected entry at t=%0t", $time);
      end else begin
        e = q1.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL dut1 t=%0t sel/en/nib/fd got=%h/%b/%h/%b want=%h/%b/%h/%b",
                   $time, a.sel, a.en, a.nib, a.fd, e.sel, e.en, e.nib, e.fd);
        end
      end
      a = {sel2, en2, nib2, fd2};
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL dut2 no expected entry at t=%0t", $time);
      end else begin
        e = q2.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL dut2 t=%0t sel/en/nib/fd got=%h/%b/%h/%b want=%h/%b/%h/%b",
                   $time, a.sel, a.en, a.nib, a.fd, e.sel, e.en, e.nib, e.fd);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load = 1'b1;
    din1 = v;
    din2 = {$urandom(), $urandom()};
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; load = 1'b1;
    din1 = 16'hFFFF; din2 = '1;
    cyc(3);
    reset = 1'b0; run = 1'b0; load = 1'b0;
    cyc(2);
    pulse_load(16'h4321);
    run = 1'b1;
    cyc(12);
    pulse_load(16'hABCD);
    cyc(60);
    cyc(19);
    run = 1'b0;
    cyc(3);
    run = 1'b1;
    cyc(40);
    cyc(27);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(40);
    for (int i = 0; i < 2500; i++) begin
      reset = ($urandom_range(0, 511) == 0);
      run   = ($urandom_range(0, 63) != 0);
      load  = (i < 1200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      din1  = 16'($urandom());
      din2  = {$urandom(), $urandom()};
      cyc(1);
    end
    reset = 1'b0; run = 1'b0; load = 1'b0;
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
